response_checker: RTL and testbench

Synthesizable response-side companion to the team's vector stimulus flow: accepts a stream of (stimulus, expected response) pairs over a valid/ready handshake and drives each stimulus onto a combinational DUT's inputs. After a fixed settle interval it samples the DUT output and scores it against the expected value. It keeps pass/fail counts and the index of the first failing vector, so a small combinational circuit under test is checked in hardware rather than by eye from a monitor trace.

---
 rtl/response_checker_pkg.sv | 25 ++
 rtl/response_checker_settle.sv | 28 ++
 rtl/response_checker.sv | 120 ++++++++++++
 tb/tb_response_checker.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/response_checker_pkg.sv
// Shared state encoding and settle-interval helpers for response_checker.
// Package only: no ports.
package response_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int unsigned SETTLE_MIN = 1;

  function automatic bit settle_ok(input int unsigned n);
    return n >= SETTLE_MIN;
  endfunction

  // Timer load value: SETTLE cycles run from n-1 down to 0.
  // An illegal n collapses to the shortest legal interval.
  function automatic int unsigned settle_load(input int unsigned n);
    return settle_ok(n) ? n - 1 : 0;
  endfunction

endpackage

// File: rtl/response_checker_settle.sv
// settle_timer: loadable down-counter with a zero flag.
// Ports: clk, rst (sync high), load/load_val, en (count down), zero.
module settle_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/response_checker.sv
// response_checker: drives stimulus to a combinational DUT, samples and scores it.
// Ports: vector handshake in, dut_stim/dut_resp, busy/done, pass/fail counts, first fail.
module response_checker
  import response_checker_pkg::*;
#(
  parameter int unsigned VEC_W      = 6,
  parameter int unsigned RESP_W     = 1,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [VEC_W-1:0]  vec_stim,
  input  logic [RESP_W-1:0] vec_exp,
  input  logic              vec_last,
  output logic [VEC_W-1:0]  dut_stim,
  input  logic [RESP_W-1:0] dut_resp,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic              first_fail_vld
);

  localparam int unsigned TW = $clog2(SETTLE_CYC) + 1;
  localparam logic [TW-1:0] LOAD = TW'(settle_load(SETTLE_CYC));

  state_t st, nxt;

  logic [RESP_W-1:0] exp_r;
  logic              last_r;
  logic [CNT_W-1:0]  idx;
  logic              tmr_zero;
  logic              accept;
  logic              clr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign accept = (st == ST_APPLY) && vec_valid;
  assign clr    = start && (st == ST_IDLE || st == ST_DONE);

  settle_timer #(.W(TW)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (LOAD),
    .en       (st == ST_SETTLE),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ST_IDLE;
    end else begin
      st <= nxt;
    end
  end

  always_comb begin
    nxt = st;
    unique case (st)
      ST_IDLE:   if (start) nxt = ST_APPLY;
      ST_APPLY:  if (vec_valid) nxt = ST_SETTLE;
      ST_SETTLE: if (tmr_zero) nxt = ST_SAMPLE;
      ST_SAMPLE: nxt = last_r ? ST_DONE : ST_APPLY;
      ST_DONE:   if (start) nxt = ST_APPLY;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dut_stim       <= '0;
      exp_r          <= '0;
      last_r         <= 1'b0;
      idx            <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      if (clr) begin
        idx            <= '0;
        pass_cnt       <= '0;
        fail_cnt       <= '0;
        first_fail_idx <= '0;
        first_fail_vld <= 1'b0;
      end
      if (accept) begin
        dut_stim <= vec_stim;
        exp_r    <= vec_exp;
        last_r   <= vec_last;
      end
      if (st == ST_SAMPLE) begin
        if (dut_resp == exp_r) begin
          pass_cnt <= sat_inc(pass_cnt);
        end else begin
          fail_cnt <= sat_inc(fail_cnt);
          if (!first_fail_vld) begin
            first_fail_idx <= idx;
            first_fail_vld <= 1'b1;
          end
        end
        idx <= sat_inc(idx);
      end
    end
  end

  assign vec_ready = (st == ST_APPLY);
  assign busy      = (st == ST_APPLY) || (st == ST_SETTLE) ||
                     (st == ST_SAMPLE);
  assign done      = (st == ST_DONE);

endmodule

// File: tb/tb_response_checker.sv
// tb_response_checker: four checker instances (settle 2/1/4, 2-bit counters)
// against a parity DUT with configurable latency.
module tb_response_checker;

  localparam int N = 4;
  localparam int SC [N] = '{2, 1, 4, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start     [N];
  logic       vec_valid [N];
  logic       vec_ready [N];
  logic [5:0] vec_stim  [N];
  logic       vec_exp   [N];
  logic       vec_last  [N];
  logic [5:0] dut_stim  [N];
  logic       dut_resp  [N];
  logic       busy      [N];
  logic       done      [N];
  logic [7:0] pass_cnt  [N];
  logic [7:0] fail_cnt  [N];
  logic [7:0] ffi       [N];
  logic       ffv       [N];

  int lat [N];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  logic [5:0] hist [N][1:5];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    response_checker #(
      .VEC_W(6), .RESP_W(1), .CNT_W(8), .SETTLE_CYC(SC[g])
    ) u_dut (
      .clk(clk), .rst(rst), .start(start[g]),
      .vec_valid(vec_valid[g]), .vec_ready(vec_ready[g]),
      .vec_stim(vec_stim[g]), .vec_exp(vec_exp[g]),
      .vec_last(vec_last[g]), .dut_stim(dut_stim[g]),
      .dut_resp(dut_resp[g]), .busy(busy[g]), .done(done[g]),
      .pass_cnt(pass_cnt[g]), .fail_cnt(fail_cnt[g]),
      .first_fail_idx(ffi[g]), .first_fail_vld(ffv[g])
    );
  end

  logic [1:0] sp, sf, si;

  response_checker #(
    .VEC_W(6), .RESP_W(1), .CNT_W(2), .SETTLE_CYC(2)
  ) u_sat (
    .clk(clk), .rst(rst), .start(start[3]),
    .vec_valid(vec_valid[3]), .vec_ready(vec_ready[3]),
    .vec_stim(vec_stim[3]), .vec_exp(vec_exp[3]),
    .vec_last(vec_last[3]), .dut_stim(dut_stim[3]),
    .dut_resp(dut_resp[3]), .busy(busy[3]), .done(done[3]),
    .pass_cnt(sp), .fail_cnt(sf),
    .first_fail_idx(si), .first_fail_vld(ffv[3])
  );

  assign pass_cnt[3] = {6'd0, sp};
  assign fail_cnt[3] = {6'd0, sf};
  assign ffi[3]      = {6'd0, si};

  function automatic logic par(input logic [5:0] s);
    return ^s;
  endfunction

  // DUT under test: parity, visible lat cycles after dut_stim changes.
  always_ff @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < N; k++) begin
      hist[k][1] <= dut_stim[k];
      for (int i = 2; i <= 5; i++) hist[k][i] <= hist[k][i-1];
    end
  end

  always_comb begin
    dut_resp = '{default: 1'b0};
    for (int k = 0; k < N; k++) dut_resp[k] = par(hist[k][lat[k]]);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int psum(input int k);
    return int'(pass_cnt[k]) + int'(fail_cnt[k]);
  endfunction

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  logic [5:0] q_stim [$];
  logic       q_exp  [$];

  task automatic run(input int k, input int stall, input bit bstart,
                     input bit tchk);
    int n, s, mx, pass_e, fail_e, ffi_e, idx_e, w, d, prev, c0;
    bit ffv_e;
    logic r;
    logic [5:0] ps;
    n = q_stim.size();
    s = SC[k];
    mx = (k == 3) ? 3 : 255;
    pass_e = 0; fail_e = 0; ffi_e = 0; idx_e = 0; ffv_e = 0;
    ps = dut_stim[k];
    start[k] = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start[k] = 1'b0;
    for (int i = 0; i < n; i++) begin
      r = (lat[k] <= s) ? par(q_stim[i]) : par(ps);
      ps = q_stim[i];
      if (r == q_exp[i]) begin
        pass_e = mn(pass_e + 1, mx);
      end else begin
        fail_e = mn(fail_e + 1, mx);
        if (!ffv_e) begin
          ffi_e = idx_e;
          ffv_e = 1'b1;
        end
      end
      idx_e = mn(idx_e + 1, mx);
      if (i == 1 && stall > 0) begin
        vec_valid[k] = 1'b0;
        prev = psum(k);
        repeat (stall) begin
          @(negedge clk);
          chk("stall_stim", dut_stim[k], q_stim[0]);
          chk("stall_cnt", psum(k), prev);
        end
        chk("stall_ready", vec_ready[k], 1);
      end
      vec_valid[k] = 1'b1;
      vec_stim[k] = q_stim[i];
      vec_exp[k] = q_exp[i];
      vec_last[k] = (i == n - 1);
      w = 0;
      while (!vec_ready[k] && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("ready_wait", w, 0);
      prev = psum(k);
      @(negedge clk);
      vec_valid[k] = 1'b0;
      vec_stim[k] = 6'($urandom);
      vec_exp[k] = 1'($urandom);
      vec_last[k] = 1'($urandom);
      chk("stim_drive", dut_stim[k], q_stim[i]);
      chk("ready_low", vec_ready[k], 0);
      d = 1;
      if (tchk) begin
        while (psum(k) == prev && d < 20) begin
          start[k] = bstart && i == 1 && d == 1;
          @(negedge clk);
          d++;
        end
        start[k] = 1'b0;
        chk("sample_lat", d, s + 2);
      end else begin
        repeat (s + 1) @(negedge clk);
      end
      if (i == n - 1) chk("done_rise", done[k], 1);
      else chk("ready_back", vec_ready[k], 1);
    end
    chk("pass_cnt", pass_cnt[k], pass_e);
    chk("fail_cnt", fail_cnt[k], fail_e);
    chk("ff_vld", ffv[k], ffv_e);
    if (ffv_e) chk("ff_idx", ffi[k], ffi_e);
    chk("busy_end", busy[k], 0);
    if (tchk && stall == 0) chk("run_len", cyc - c0, 1 + n * (s + 2));
  endtask

  typedef struct {
    logic [5:0] stim;
    logic       resp;
  } tv_t;

  tv_t tbl [4];
  logic [5:0] sv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{6'b100100, 1'b0};
    tbl[1] = '{6'b001100, 1'b0};
    tbl[2] = '{6'b101100, 1'b1};
    tbl[3] = '{6'b101101, 1'b0};
    for (int k = 0; k < N; k++) begin
      start[k] = 1'b0; vec_valid[k] = 1'b0; vec_stim[k] = '0;
      vec_exp[k] = 1'b0; vec_last[k] = 1'b0; lat[k] = SC[k];
    end
    rst = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", vec_ready[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_stim", dut_stim[0], 0);
    chk("rst_pass", pass_cnt[0], 0);
    chk("rst_fail", fail_cnt[0], 0);
    chk("rst_ffi", ffi[0], 0);
    chk("rst_ffv", ffv[0], 0);

    // clean table run
    q_stim.delete(); q_exp.delete();
    for (int i = 0; i < 4; i++) begin
      q_stim.push_back(tbl[i].stim);
      q_exp.push_back(tbl[i].resp);
    end
    run(0, 0, 0, 1);
    chk("clean_pass", pass_cnt[0], 4);
    chk("clean_fail", fail_cnt[0], 0);
    chk("clean_ffv", ffv[0], 0);

    // restart from DONE with mismatches on vectors 1 and 3
    q_exp.delete();
    for (int i = 0; i < 4; i++)
      q_exp.push_back(tbl[i].resp ^ (i == 1 || i == 3));
    run(0, 0, 0, 1);
    chk("mis_pass", pass_cnt[0], 2);
    chk("mis_fail", fail_cnt[0], 2);
    chk("mis_ffi", ffi[0], 1);
    chk("mis_ffv", ffv[0], 1);

    // source stall plus start while busy, random expectations
    q_stim.delete(); q_exp.delete();
    for (int i = 0; i < 5; i++) begin
      q_stim.push_back(6'($urandom));
      q_exp.push_back(1'($urandom));
    end
    run(0, 5, 1, 1);

    // settle intervals 1 and 4
    for (int k = 1; k <= 2; k++) begin
      q_stim.delete(); q_exp.delete();
      for (int i = 0; i < 6; i++) begin
        q_stim.push_back(6'($urandom));
        q_exp.push_back(1'($urandom));
      end
      run(k, 0, k == 1, 1);
    end

    // DUT one cycle too slow: stimulus parity alternates so each sample differs
    for (int k = 1; k <= 2; k++) begin
      lat[k] = SC[k] + 1;
      q_stim.delete(); q_exp.delete();
      for (int i = 0; i < 6; i++) begin
        sv = 6'($urandom);
        if (par(sv) != ((i % 2) == 1)) sv[0] = ~sv[0];
        q_stim.push_back(sv);
        q_exp.push_back(par(sv));
      end
      run(k, 0, 0, 1);
      chk("late_detect", fail_cnt[k] >= 5, 1);
      lat[k] = SC[k];
    end

    // 2-bit counters saturate
    q_stim.delete(); q_exp.delete();
    for (int i = 0; i < 5; i++) begin
      sv = 6'($urandom);
      q_stim.push_back(sv);
      q_exp.push_back(par(sv));
    end
    run(3, 0, 0, 0);
    chk("sat_pass", pass_cnt[3], 3);
    chk("sat_fail", fail_cnt[3], 0);

    // reset in the middle of SETTLE
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    vec_valid[0] = 1'b1; vec_stim[0] = 6'h2a;
    vec_exp[0] = 1'b0; vec_last[0] = 1'b0;
    @(negedge clk);
    vec_valid[0] = 1'b0;
    chk("mid_busy", busy[0], 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("mrst_ready", vec_ready[0], 0);
    chk("mrst_busy", busy[0], 0);
    chk("mrst_done", done[0], 0);
    chk("mrst_stim", dut_stim[0], 0);
    chk("mrst_pass", pass_cnt[0], 0);
    chk("mrst_fail", fail_cnt[0], 0);
    chk("mrst_ffv", ffv[0], 0);
    repeat (4) @(negedge clk);
    chk("idle_ready", vec_ready[0], 0);
    chk("idle_done", done[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
